adder_tree_accum: RTL and testbench
===================================

# adder_tree_accum

Parametrised, fully pipelined signed adder tree that reduces N_IN operands per beat and accumulates the tree sums over a multi-beat group. Group boundaries are marked by first/last flags. At the end of a group it scales the accumulated value by a per-group scaler, rounds, saturates and emits the result. It replaces the fixed-size kernel, channel and scaler arithmetic in the convolution datapath with one reusable block, and adds backpressure.

## Interface
- N_IN, 25: operands per beat; N_IN >= 2
- IN_WIDTH, 16: signed operand width
- ACC_WIDTH, 32: signed accumulator width; must be >= IN_WIDTH + D
- SCALER_WIDTH, 16: signed scaler width
- SHIFT, 8: right shift after scaling; SHIFT >= 1
- OUT_WIDTH, 16: signed result width
- D (local): ceil(log2(N_IN)), the number of tree levels
- fast_clk  in  1  clock; all registers update on the rising edge
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_first  in  1  beat starts a group
- in_last  in  1  beat ends a group
- in_data  in  N_IN*IN_WIDTH  operand i at bits [(i+1)*IN_WIDTH-1 : i*IN_WIDTH]
- in_scaler  in  SCALER_WIDTH  sampled only with the last beat
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_data  out  OUT_WIDTH  scaled, rounded, saturated group result
- out_sat  out  1  saturation occurred anywhere in this group

## Operation
- Tree: D registered levels. Each level sums adjacent pairs. An odd leftover element is registered unchanged. Operands are sign-extended; level k width is IN_WIDTH+k.
- valid, first, last and scaler travel alongside the tree in a sideband shift register. Bubbles (in_valid=0) propagate as invalid and never modify state.
- Accumulate stage, on a valid tree output:
  - first=1: acc <= sign-extended sum.
  - first=0: acc <= acc + sum.
  - The add saturates to the ACC_WIDTH signed range. Any clamp sets the group's sat flag.
  - first=1 clears the sat flag before OR-ing in the new event.
- Missing first: a group with no first beat adds onto the existing acc. After reset, acc is 0.
- first=last=1 on one beat: single-beat group.
- Scale stage, on a valid beat with last=1:
  - p = acc * scaler, full width ACC_WIDTH+SCALER_WIDTH, signed.
  - r = (p + 2^(SHIFT-1)) >>> SHIFT (round half up).
  - r is clamped to the OUT_WIDTH signed range. A clamp sets sat.
  - Loads out_data <= r and out_sat <= sat, and sets out_valid.
- Result handshake: out_valid clears on out_valid && out_ready unless a new result loads in the same cycle.
- Stall = out_valid && !out_ready.
  - While stalled, every pipeline, sideband, accumulator and output register holds.
  - in_ready = !stall, driven combinationally.
  - Beats offered while in_ready=0 are not consumed.
- Non-last valid beats produce no output.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_sat=0.
  - in_ready=1.
  - acc=0, sat flag=0.
  - All tree, sideband and scaler registers 0.
- Asserting rst mid-group discards all in-flight beats and any pending result. No output appears for that group.
- Latency: a last beat accepted at edge k gives out_valid=1 after edge k+D+2, with no stall in between. This is D tree levels, plus 1 accumulate cycle, plus 1 scale cycle. Each stall cycle adds 1.
- Throughput:
  - One beat per cycle when out_ready=1.
  - Back-to-back single-beat groups give one result per cycle.
- out_ready=1 continuously: out_valid is a 1-cycle pulse per group.
- Result accepted in the same cycle a new one arrives: the new result replaces it with no gap.
- Defaults (N_IN=25): D=5, latency 7.

## Test plan
- Reset:
  - Stimulus: drive rst=0 during a 3-beat group.
  - Response: out_valid=0, out_data=0, out_sat=0, in_ready=1. After release, no stale output appears.
  - Stimulus: then send a fresh single-beat group of all 1s with scaler=256.
  - Response: out_data=25.
- Single beat, defaults:
  - Stimulus: all 25 operands =1, first=last=1, scaler=256, out_ready=1.
  - Response: out_valid pulses 7 cycles after acceptance; out_data=25, out_sat=0.
- Three-beat group with bubbles:
  - Stimulus: beats of all 2, all -1, all 3, with 2 idle cycles between beats; scaler=256.
  - Response: sums 50, -25, 75; out_data=100; exactly one out_valid pulse.
- Rounding:
  - Stimulus: operand0=3, others 0, scaler=128.
  - Response: p=384; 384/256=1.5 rounds to out_data=2.
  - Stimulus: all operands -32768, scaler=1.
  - Response: out_data=-3200, out_sat=0.
- Saturation:
  - Stimulus: all operands 32767, scaler=32767.
  - Response: out_data=32767, out_sat=1.
  - Stimulus: next group of all 1s, scaler=256.
  - Response: out_sat=0, out_data=25.
- Backpressure:
  - Stimulus: 10 consecutive single-beat groups with operand0=g (g=1..10), scaler=256; out_ready held 0 for 5 cycles once the first result appears.
  - Response: in_ready=0 and out_data stable throughout the stall. Results 1..10 appear in order with none lost or duplicated.

Source files
------------

// File: rtl/adder_tree_accum_if.sv
// Beat-in / result-out handshake bundle for adder_tree_accum.
// The producer/consumer side uses master; the datapath uses slave.
interface adder_tree_accum_if #(
  parameter int unsigned N_IN         = 25,
  parameter int unsigned IN_WIDTH     = 16,
  parameter int unsigned SCALER_WIDTH = 16,
  parameter int unsigned OUT_WIDTH    = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_first;
  logic                         in_last;
  logic [N_IN*IN_WIDTH-1:0]     in_data;
  logic [SCALER_WIDTH-1:0]      in_scaler;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_WIDTH-1:0]         out_data;
  logic                         out_sat;

  modport master (
    output in_valid, in_first, in_last, in_data, in_scaler, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, in_data, in_scaler, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/adder_tree_accum.sv
// Pipelined signed adder tree with group accumulation, scaling, rounding and
// saturation; the whole pipeline freezes while a result is held unaccepted.
module adder_tree_accum #(
  parameter int unsigned N_IN         = 25,
  parameter int unsigned IN_WIDTH     = 16,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned SCALER_WIDTH = 16,
  parameter int unsigned SHIFT        = 8,
  parameter int unsigned OUT_WIDTH    = 16
) (
  input  logic              fast_clk,
  input  logic              rst,
  adder_tree_accum_if.slave bus
);
  localparam int unsigned D   = $clog2(N_IN);
  localparam int unsigned TW  = IN_WIDTH + D;
  localparam int unsigned AW1 = ACC_WIDTH + 1;
  localparam int unsigned PW  = ACC_WIDTH + SCALER_WIDTH;
  localparam int unsigned PW1 = PW + 1;

  localparam logic signed [AW1-1:0] ACC_MAX = AW1'($signed({1'b0, {(ACC_WIDTH-1){1'b1}}}));
  localparam logic signed [AW1-1:0] ACC_MIN = AW1'($signed({1'b1, {(ACC_WIDTH-1){1'b0}}}));
  localparam logic signed [PW1-1:0] OUT_MAX = PW1'($signed({1'b0, {(OUT_WIDTH-1){1'b1}}}));
  localparam logic signed [PW1-1:0] OUT_MIN = PW1'($signed({1'b1, {(OUT_WIDTH-1){1'b0}}}));
  localparam logic signed [PW1-1:0] RND     = PW1'(1) << (SHIFT - 1);

  function automatic int lvl_cnt(input int k);
    return (int'(N_IN) + (1 << k) - 1) >> k;
  endfunction

  typedef struct packed {
    logic                    valid;
    logic                    first;
    logic                    last;
    logic [SCALER_WIDTH-1:0] scaler;
  } side_t;

  logic stall_c;
  assign stall_c      = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall_c;

  // Reduction tree: level 0 is the raw operand view, levels 1..D are registered.
  for (genvar k = 0; k <= D; k++) begin : g_lvl
    localparam int unsigned LW  = IN_WIDTH + k;
    localparam int          CNT = lvl_cnt(k);
    logic signed [LW-1:0] v [CNT];

    if (k == 0) begin : g_in
      for (genvar i = 0; i < CNT; i++) begin : g_op
        assign v[i] = bus.in_data[i*IN_WIDTH +: IN_WIDTH];
      end
    end else begin : g_sum
      localparam int PCNT = lvl_cnt(k - 1);
      always_ff @(posedge fast_clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < CNT; i++) v[i] <= '0;
        end else if (!stall_c) begin
          for (int i = 0; i < PCNT / 2; i++)
            v[i] <= LW'(g_lvl[k-1].v[2*i]) + LW'(g_lvl[k-1].v[2*i+1]);
          if (PCNT % 2 == 1) v[CNT-1] <= LW'(g_lvl[k-1].v[PCNT-1]);
        end
      end
    end
  end

  logic signed [TW-1:0] tree_sum_c;
  assign tree_sum_c = g_lvl[D].v[0];

  // Sideband travelling in lockstep with the tree levels.
  side_t side_q [D];
  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) side_q[i] <= '0;
    end else if (!stall_c) begin
      side_q[0].valid  <= bus.in_valid;
      side_q[0].first  <= bus.in_first;
      side_q[0].last   <= bus.in_last;
      side_q[0].scaler <= bus.in_scaler;
      for (int i = 1; i < D; i++) side_q[i] <= side_q[i-1];
    end
  end

  // Saturating accumulate; a first beat restarts both the sum and the sat flag.
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        sat_q;
  logic                        fire_q;
  logic [SCALER_WIDTH-1:0]     scl_q;
  logic signed [AW1-1:0]       acc_base_c;
  logic signed [AW1-1:0]       acc_sum_c;
  logic signed [ACC_WIDTH-1:0] acc_next_c;
  logic                        acc_clip_c;

  always_comb begin
    acc_base_c = AW1'(acc_q);
    if (side_q[D-1].first) acc_base_c = '0;
    acc_sum_c  = acc_base_c + AW1'(tree_sum_c);
    acc_next_c = ACC_WIDTH'(acc_sum_c);
    acc_clip_c = 1'b0;
    if (acc_sum_c > ACC_MAX) begin
      acc_next_c = ACC_WIDTH'(ACC_MAX);
      acc_clip_c = 1'b1;
    end else if (acc_sum_c < ACC_MIN) begin
      acc_next_c = ACC_WIDTH'(ACC_MIN);
      acc_clip_c = 1'b1;
    end
  end

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      sat_q  <= 1'b0;
      fire_q <= 1'b0;
      scl_q  <= '0;
    end else if (!stall_c) begin
      fire_q <= side_q[D-1].valid && side_q[D-1].last;
      scl_q  <= side_q[D-1].scaler;
      if (side_q[D-1].valid) begin
        acc_q <= acc_next_c;
        sat_q <= (sat_q && !side_q[D-1].first) || acc_clip_c;
      end
    end
  end

  // Multiplier is registered on its own so rounding/clamping sits in the next cycle.
  logic signed [PW-1:0] prod_q;
  logic                 prod_valid_q;
  logic                 prod_sat_q;

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_sat_q   <= 1'b0;
    end else if (!stall_c) begin
      prod_valid_q <= fire_q;
      prod_sat_q   <= sat_q;
      prod_q       <= PW'(acc_q) * PW'($signed(scl_q));
    end
  end

  logic signed [PW1-1:0]       rnd_c;
  logic signed [OUT_WIDTH-1:0] out_next_c;
  logic                        out_clip_c;

  always_comb begin
    rnd_c      = (PW1'(prod_q) + RND) >>> SHIFT;
    out_next_c = OUT_WIDTH'(rnd_c);
    out_clip_c = 1'b0;
    if (rnd_c > OUT_MAX) begin
      out_next_c = OUT_WIDTH'(OUT_MAX);
      out_clip_c = 1'b1;
    end else if (rnd_c < OUT_MIN) begin
      out_next_c = OUT_WIDTH'(OUT_MIN);
      out_clip_c = 1'b1;
    end
  end

  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic                        out_sat_q;

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (!stall_c) begin
      out_valid_q <= prod_valid_q;
      if (prod_valid_q) begin
        out_data_q <= out_next_c;
        out_sat_q  <= prod_sat_q || out_clip_c;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_adder_tree_accum.sv
// Scoreboard bench for adder_tree_accum: a reference model pushes expected
// group results at beat acceptance; a monitor collects what the DUT emits.
module tb_adder_tree_accum;
  localparam int N_IN = 25, IN_WIDTH = 16, ACC_WIDTH = 32;
  localparam int SCALER_WIDTH = 16, SHIFT = 8, OUT_WIDTH = 16;
  localparam int DW  = N_IN * IN_WIDTH;
  localparam int LAT = $clog2(N_IN) + 2;

  logic fast_clk = 1'b0;
  logic rst = 1'b0;
  always #5 fast_clk = ~fast_clk;

  adder_tree_accum_if #(.N_IN(N_IN), .IN_WIDTH(IN_WIDTH), .SCALER_WIDTH(SCALER_WIDTH),
                        .OUT_WIDTH(OUT_WIDTH)) bus ();

  adder_tree_accum #(.N_IN(N_IN), .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH),
                     .SCALER_WIDTH(SCALER_WIDTH), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH))
    dut (.fast_clk(fast_clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [OUT_WIDTH:0] exp_q [$];
  logic [OUT_WIDTH:0] got_q [$];
  int got_cyc [$];
  longint m_acc = 0;
  bit m_sat = 1'b0;

  always @(posedge fast_clk) cyc <= cyc + 1;

  // Capture each accepted result well after the edge that produced it.
  always begin
    @(negedge fast_clk);
    #3;
    if (rst && bus.out_valid && bus.out_ready) begin
      got_q.push_back({bus.out_data, bus.out_sat});
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] fill(input int v);
    logic [DW-1:0] d;
    for (int i = 0; i < N_IN; i++) d[i*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(v);
    return d;
  endfunction

  function automatic logic [DW-1:0] op0(input int v);
    logic [DW-1:0] d;
    d = '0;
    d[IN_WIDTH-1:0] = IN_WIDTH'(v);
    return d;
  endfunction

  // Reference arithmetic on 64-bit integers, independent of the RTL widths.
  task automatic model_beat(input logic [DW-1:0] d, input bit f, input bit l, input int sc);
    longint s, a, p, r;
    longint amax, omax;
    bit clip;
    amax = (longint'(1) << (ACC_WIDTH - 1)) - 1;
    omax = (longint'(1) << (OUT_WIDTH - 1)) - 1;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += longint'($signed(d[i*IN_WIDTH +: IN_WIDTH]));
    a = f ? s : m_acc + s;
    clip = 1'b0;
    if (a > amax) begin a = amax; clip = 1'b1; end
    else if (a < -amax - 1) begin a = -amax - 1; clip = 1'b1; end
    m_acc = a;
    m_sat = (f ? 1'b0 : m_sat) | clip;
    if (l) begin
      p = m_acc * longint'(sc);
      r = (p + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
      clip = 1'b0;
      if (r > omax) begin r = omax; clip = 1'b1; end
      else if (r < -omax - 1) begin r = -omax - 1; clip = 1'b1; end
      exp_q.push_back({OUT_WIDTH'(r), m_sat | clip});
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit f, input bit l, input int sc,
                           input int idle);
    bit ok;
    int n;
    bus.in_valid = 1'b1; bus.in_first = f; bus.in_last = l;
    bus.in_data = d; bus.in_scaler = SCALER_WIDTH'(sc);
    ok = 1'b0; n = 0;
    while (!ok && n < 200) begin
      @(negedge fast_clk);
      #2;
      ok = bus.in_ready;
      @(posedge fast_clk);
      #1;
      n++;
    end
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: beat not accepted within %0d cycles", n);
    end else begin
      model_beat(d, f, l, sc);
    end
    repeat (idle) begin @(posedge fast_clk); #1; end
  endtask

  task automatic test_reset();
    int n;
    logic [OUT_WIDTH:0] g, e;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.in_data = '0; bus.in_scaler = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge fast_clk);
    #1;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d, expected 0", $signed(bus.out_data)); end
    if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b, expected 0", bus.out_sat); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    rst = 1'b1;
    @(posedge fast_clk);
    #1;
    send_beat(fill(1), 1'b1, 1'b0, 256, 0);
    send_beat(fill(1), 1'b0, 1'b0, 256, 0);
    send_beat(fill(1), 1'b0, 1'b1, 256, 0);
    repeat (2) @(posedge fast_clk);
    #2;
    rst = 1'b0;
    #1;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.out_data !== '0) begin errors++; $display("FAIL midreset_out_data: got %0d, expected 0", $signed(bus.out_data)); end
    if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL midreset_out_sat: got %b, expected 0", bus.out_sat); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b, expected 1", bus.in_ready); end
    exp_q.delete(); m_acc = 0; m_sat = 1'b0;
    repeat (2) @(posedge fast_clk);
    #1;
    rst = 1'b1;
    repeat (15) @(posedge fast_clk);
    #1;
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL reset_stale: got %0d results, expected 0", got_q.size()); end
    got_q.delete(); got_cyc.delete();
    send_beat(fill(1), 1'b1, 1'b1, 256, 0);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin @(posedge fast_clk); n++; end
    repeat (12) @(posedge fast_clk);
    #1;
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL reset_count: got %0d results, expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_result: got data=%0d sat=%b, expected data=%0d sat=%b", $signed(g[OUT_WIDTH:1]), g[0], $signed(e[OUT_WIDTH:1]), e[0]); end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_single();
    int n;
    logic [OUT_WIDTH:0] g, e;
    send_beat(fill(1), 1'b1, 1'b1, 256, 0);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin @(posedge fast_clk); n++; end
    repeat (12) @(posedge fast_clk);
    #1;
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] - acc_cyc != LAT) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, expected %0d", (got_cyc.size() == 0) ? -1 : got_cyc[0] - acc_cyc, LAT);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d results, expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL single_result: got data=%0d sat=%b, expected data=%0d sat=%b", $signed(g[OUT_WIDTH:1]), g[0], $signed(e[OUT_WIDTH:1]), e[0]); end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_bubbles();
    int n;
    logic [OUT_WIDTH:0] g, e;
    send_beat(fill(2), 1'b1, 1'b0, 256, 2);
    send_beat(fill(-1), 1'b0, 1'b0, 256, 2);
    send_beat(fill(3), 1'b0, 1'b1, 256, 0);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin @(posedge fast_clk); n++; end
    repeat (12) @(posedge fast_clk);
    #1;
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bubbles_count: got %0d results, expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL bubbles_result: got data=%0d sat=%b, expected data=%0d sat=%b", $signed(g[OUT_WIDTH:1]), g[0], $signed(e[OUT_WIDTH:1]), e[0]); end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_rounding();
    int n;
    logic [OUT_WIDTH:0] g, e;
    send_beat(op0(3), 1'b1, 1'b1, 128, 0);
    send_beat(fill(-32768), 1'b1, 1'b1, 1, 0);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin @(posedge fast_clk); n++; end
    repeat (12) @(posedge fast_clk);
    #1;
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL round_count: got %0d results, expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL round_result: got data=%0d sat=%b, expected data=%0d sat=%b", $signed(g[OUT_WIDTH:1]), g[0], $signed(e[OUT_WIDTH:1]), e[0]); end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_saturation();
    int n;
    logic [OUT_WIDTH:0] g, e;
    send_beat(fill(32767), 1'b1, 1'b1, 32767, 0);
    send_beat(fill(1), 1'b1, 1'b1, 256, 0);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin @(posedge fast_clk); n++; end
    repeat (12) @(posedge fast_clk);
    #1;
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL sat_count: got %0d results, expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL sat_result: got data=%0d sat=%b, expected data=%0d sat=%b", $signed(g[OUT_WIDTH:1]), g[0], $signed(e[OUT_WIDTH:1]), e[0]); end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [OUT_WIDTH:0] g, e;
    for (int k = 1; k <= 4; k++) send_beat(op0(k * 5), 1'b1, 1'b1, 256, 0);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin @(posedge fast_clk); n++; end
    repeat (12) @(posedge fast_clk);
    #1;
    for (int k = 1; k < got_cyc.size(); k++) begin
      checks++;
      if (got_cyc[k] - got_cyc[k-1] != 1) begin errors++; $display("FAIL b2b_spacing: got %0d cycles between results, expected 1", got_cyc[k] - got_cyc[k-1]); end
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d results, expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_result: got data=%0d sat=%b, expected data=%0d sat=%b", $signed(g[OUT_WIDTH:1]), g[0], $signed(e[OUT_WIDTH:1]), e[0]); end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_backpressure();
    int n;
    logic [OUT_WIDTH:0] g, e;
    logic [OUT_WIDTH-1:0] held;
    fork
      begin
        for (int k = 1; k <= 10; k++) send_beat(op0(k), 1'b1, 1'b1, 256, 0);
      end
      begin
        n = 0;
        while (!bus.out_valid && n < 200) begin @(negedge fast_clk); n++; end
        if (!bus.out_valid) begin
          checks++; errors++;
          $display("FAIL bp_timeout: no result within %0d cycles", n);
        end else begin
          bus.out_ready = 1'b0;
          held = bus.out_data;
          repeat (5) begin
            #1;
            checks += 3;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", bus.in_ready); end
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, expected 1", bus.out_valid); end
            if (bus.out_data !== held) begin errors++; $display("FAIL bp_hold: got %0d, expected %0d", $signed(bus.out_data), $signed(held)); end
            @(negedge fast_clk);
          end
          bus.out_ready = 1'b1;
        end
      end
    join
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin @(posedge fast_clk); n++; end
    repeat (12) @(posedge fast_clk);
    #1;
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d results, expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL bp_result: got data=%0d sat=%b, expected data=%0d sat=%b", $signed(g[OUT_WIDTH:1]), g[0], $signed(e[OUT_WIDTH:1]), e[0]); end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_bubbles();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
